// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial shared-adder controller.
package adder_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/two_bit_adder_cin.sv
// Shared 2-bit adder slice with carry in and carry out.
module two_bit_adder_cin (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       c_in,
  output logic [1:0] s,
  output logic       c_out
);

  always_comb begin
    {c_out, s} = {1'b0, a} + {1'b0, b} + {2'b00, c_in};
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter and sequencer feeding WIDTH-bit additions through one
// 2-bit adder slice, least significant digit first.
module adder_share_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_sum,
  output logic             rsp_id,
  output logic             busy
);

  localparam int unsigned DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(DIGITS) + 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, result;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               last_id;
  logic               id_q;
  logic               grant;
  logic               accept;
  logic               last_digit;
  logic [DIGIT_W-1:0] slice_s;
  logic               slice_c;

  two_bit_adder_cin u_slice (
    .a     (a_sh[DIGIT_W-1:0]),
    .b     (b_sh[DIGIT_W-1:0]),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_c)
  );

  assign last_digit = (cnt == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    // Sole valid requester wins; on contention the one not served last wins.
    if (req0_valid && req1_valid) grant = ~last_id;
    else                          grant = req1_valid;
    unique case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        accept     = req0_ready || req1_ready;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      result  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      last_id <= 1'b1;
      id_q    <= 1'b0;
    end else if (accept) begin
      a_sh    <= grant ? req1_a : req0_a;
      b_sh    <= grant ? req1_b : req0_b;
      result  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      last_id <= grant;
      id_q    <= grant;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT_W;
      b_sh   <= b_sh >> DIGIT_W;
      // New digit enters at the top so the first digit ends up at bit 0.
      result <= WIDTH'({slice_s, result} >> DIGIT_W);
      carry  <= slice_c;
      cnt    <= cnt + 1'b1;
    end
  end

  assign rsp_sum = (state == DONE) ? {carry, result} : '0;
  assign rsp_id  = id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl at WIDTH=8.
module tb_adder_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [8:0] rsp_sum;

  typedef struct {
    logic       id;
    logic [8:0] sum;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_rsp    = 0;

  always #5 clk = ~clk;

  adder_share_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n && req0_valid && req1_valid)
      check("one_ready", 32'(req0_ready & req1_ready), 0);
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        n_rsp++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [7:0] b);
    if (id) begin req1_valid = v; req1_a = a; req1_b = b; end
    else    begin req0_valid = v; req0_a = a; req0_b = b; end
  endtask

  // Issues one operation, pushes its expectation and waits for the response.
  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b, input bit push);
    bit seen = 0;
    int n = 0;
    int lat = 0;
    set_req(id, 1'b1, a, b);
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = id ? req1_ready : req0_ready;
      if (!seen) begin step(); n++; end
    end
    if (!seen) begin
      check("ready_timeout", 0, 1);
      set_req(id, 1'b0, a, b);
      return;
    end
    if (push) sb.push_back('{id, {1'b0, a} + {1'b0, b}});
    step();
    set_req(id, 1'b0, a, b);
    if (!push) return;
    while (!rsp_valid && lat < 20) begin
      if (!busy) check("busy_run", 32'(busy), 1);
      step();
      lat++;
    end
    check("latency", lat, 4);
    n = 0;
    while (rsp_valid && rsp_ready && n < 50) begin step(); n++; end
  endtask

  initial begin
    exp_t       e;
    logic [8:0] held_sum;
    int         n;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #12;
    check("rst_req0_ready", 32'(req0_ready), 0);
    check("rst_req1_ready", 32'(req1_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_sum", 32'(rsp_sum), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    step();

    do_op(1'b0, 8'h5A, 8'h3C, 1'b1);
    do_op(1'b1, 8'hFF, 8'h01, 1'b1);
    do_op(1'b1, 8'hFF, 8'hFF, 1'b1);
    check("n_rsp_basic", n_rsp, 3);

    // Contention: last_id is 1, so req0 wins first and grants alternate.
    for (int i = 0; i < 4; i++) sb.push_back((i % 2 == 0) ? '{1'b0, 9'h003} : '{1'b1, 9'h030});
    set_req(1'b0, 1'b1, 8'h01, 8'h02);
    set_req(1'b1, 1'b1, 8'h10, 8'h20);
    n = 0;
    while (n_rsp < 7 && n < 100) begin step(); n++; end
    set_req(1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 8'h00, 8'h00);
    check("n_rsp_rr", n_rsp, 7);
    repeat (3) step();

    // Backpressure in DONE.
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'h77, 8'h11);
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    check("bp_reached_done", 32'(rsp_valid), 1);
    set_req(1'b0, 1'b1, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, 8'h22, 8'h33);
    held_sum = 9'h088;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_sum", 32'(rsp_sum), 32'(held_sum));
      check("bp_id", 32'(rsp_id), 0);
      check("bp_ready0", 32'(req0_ready), 0);
      check("bp_ready1", 32'(req1_ready), 0);
      step();
    end
    sb.push_back('{1'b0, held_sum});
    rsp_ready = 1'b1;
    step();
    check("hs_no_accept", 32'(busy), 0);
    check("hs_rsp_valid", 32'(rsp_valid), 0);
    // last_id is now 0, so req1 wins the contention right after the handshake.
    check("post_hs_ready1", 32'(req1_ready), 1);
    sb.push_back('{1'b1, 9'h055});
    step();
    set_req(1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 8'h00, 8'h00);
    check("post_hs_busy", 32'(busy), 1);
    n = 0;
    while (n_rsp < 9 && n < 30) begin step(); n++; end
    check("n_rsp_bp", n_rsp, 9);
    repeat (2) step();

    // Reset in RUN discards the in-flight operation.
    do_op(1'b1, 8'hAB, 8'hCD, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_rsp_id", 32'(rsp_id), 0);
    check("arst_rsp_sum", 32'(rsp_sum), 0);
    check("arst_ready0", 32'(req0_ready), 0);
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin step(); if (rsp_valid) n++; end
    check("arst_no_rsp", n, 0);
    do_op(1'b0, 8'h12, 8'h34, 1'b1);

    // req1 pulses valid for one cycle while busy; it must never be accepted.
    set_req(1'b0, 1'b1, 8'h80, 8'h80);
    @(negedge clk);
    sb.push_back('{1'b0, 9'h100});
    step();
    set_req(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    set_req(1'b1, 1'b1, 8'h44, 8'h44);
    @(negedge clk);
    check("drop_ready1", 32'(req1_ready), 0);
    step();
    set_req(1'b1, 1'b0, 8'h00, 8'h00);
    n = 0;
    while (n_rsp < 11 && n < 30) begin step(); n++; end
    check("n_rsp_drop", n_rsp, 11);
    n = 0;
    for (int i = 0; i < 10; i++) begin step(); if (busy || rsp_valid) n++; end
    check("drop_no_op", n, 0);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
